// File: rtl/mips_pkg.sv
// mips_pkg: shared ALU op encodings and the EX control bundle
package mips_pkg;
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b01;
  localparam logic [1:0] ALU_SLT = 2'b11;
  typedef struct packed {
    logic       branch;
    logic       jump;
    logic       RegWr;
    logic       ALUSrc;
    logic       MemWr;
    logic       MemToReg;
    logic       jumpR;
    logic [1:0] ALUcntrl;
  } ctrl_t;
  localparam ctrl_t BUBBLE = '0;
endpackage

// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs and EX-side outputs of the ID/EX pipeline register
interface id_ex_stage_if #(parameter int DATA_W = 32, parameter int REG_W = 5);
  logic id_valid, id_branch, id_jump, id_RegDst, id_RegWr, id_ALUSrc, id_MemWr, id_MemToReg, id_jumpR;
  logic [1:0] id_ALUcntrl;
  logic [REG_W-1:0] id_rs, id_rt, id_rd;
  logic [DATA_W-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
  logic flush, stall_out;
  logic ex_valid, ex_branch, ex_jump, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemToReg, ex_jumpR;
  logic [1:0] ex_ALUcntrl;
  logic [REG_W-1:0] ex_rs, ex_rt, ex_wrReg;
  logic [DATA_W-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
  modport master (
    output id_valid, id_branch, id_jump, id_RegDst, id_RegWr, id_ALUSrc, id_MemWr, id_MemToReg, id_jumpR,
    output id_ALUcntrl, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4, flush,
    input stall_out, ex_valid, ex_branch, ex_jump, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemToReg, ex_jumpR,
    input ex_ALUcntrl, ex_rs, ex_rt, ex_wrReg, ex_rdata1, ex_rdata2, ex_imm, ex_pc4
  );
  modport slave (
    input id_valid, id_branch, id_jump, id_RegDst, id_RegWr, id_ALUSrc, id_MemWr, id_MemToReg, id_jumpR,
    input id_ALUcntrl, id_rs, id_rt, id_rd, id_rdata1, id_rdata2, id_imm, id_pc4, flush,
    output stall_out, ex_valid, ex_branch, ex_jump, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemToReg, ex_jumpR,
    output ex_ALUcntrl, ex_rs, ex_rt, ex_wrReg, ex_rdata1, ex_rdata2, ex_imm, ex_pc4
  );
endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// hazard_detect: load-use detection between the load in EX and the sources of the ID instruction
module hazard_detect #(parameter int REG_W = 5) (
  input  logic             id_valid,
  input  logic             jump,
  input  logic             branch,
  input  logic             MemWr,
  input  logic             RegWr,
  input  logic             RegDst,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             ex_valid,
  input  logic             ex_MemToReg,
  input  logic             ex_RegWr,
  input  logic [REG_W-1:0] ex_wrReg,
  output logic             load_use
);
  logic uses_rs, uses_rt;
  assign uses_rs = id_valid && !jump;
  assign uses_rt = id_valid && (MemWr || branch || (RegWr && RegDst));
  assign load_use = ex_valid && ex_MemToReg && ex_RegWr && (ex_wrReg != '0) &&
                    ((uses_rs && ex_wrReg == id_rs) || (uses_rt && ex_wrReg == id_rt));
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and saturating event counters
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  id_ex_stage_if.slave     bus,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  logic vld, flush, regdst, load_use, bubble, stall, ex_vld;
  ctrl_t id_c, ex_c;
  logic [REG_W-1:0] wr_id, ex_wr;
  // Decoder bits may carry X; only a definite 1 counts as set
  assign vld = bus.id_valid === 1'b1;
  assign flush = bus.flush === 1'b1;
  assign regdst = bus.id_RegDst === 1'b1;
  assign id_c = '{
    branch:   vld && (bus.id_branch === 1'b1),
    jump:     vld && (bus.id_jump === 1'b1),
    RegWr:    vld && (bus.id_RegWr === 1'b1),
    ALUSrc:   vld && (bus.id_ALUSrc === 1'b1),
    MemWr:    vld && (bus.id_MemWr === 1'b1),
    MemToReg: vld && (bus.id_MemToReg === 1'b1),
    jumpR:    vld && (bus.id_jumpR === 1'b1),
    ALUcntrl: vld ? bus.id_ALUcntrl : ALU_ADD
  };
  assign wr_id = !id_c.RegWr ? '0 : regdst ? bus.id_rd : bus.id_rt;
  hazard_detect #(.REG_W(REG_W)) u_hazard (
    .id_valid    (vld),
    .jump        (id_c.jump),
    .branch      (id_c.branch),
    .MemWr       (id_c.MemWr),
    .RegWr       (id_c.RegWr),
    .RegDst      (regdst),
    .id_rs       (bus.id_rs),
    .id_rt       (bus.id_rt),
    .ex_valid    (ex_vld),
    .ex_MemToReg (ex_c.MemToReg),
    .ex_RegWr    (ex_c.RegWr),
    .ex_wrReg    (ex_wr),
    .load_use    (load_use)
  );
  // A flush kills the ID instruction outright, so it overrides the stall
  assign stall = load_use && !flush && !reset;
  assign bubble = flush || load_use;
  assign bus.stall_out = stall;
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_c <= BUBBLE;
      ex_vld <= 1'b0;
      ex_wr <= '0;
      bus.ex_rs <= '0;
      bus.ex_rt <= '0;
      bus.ex_rdata1 <= '0;
      bus.ex_rdata2 <= '0;
      bus.ex_imm <= '0;
      bus.ex_pc4 <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      ex_c <= bubble ? BUBBLE : id_c;
      ex_vld <= vld && !bubble;
      ex_wr <= bubble ? '0 : wr_id;
      bus.ex_rs <= bus.id_rs;
      bus.ex_rt <= bus.id_rt;
      bus.ex_rdata1 <= bus.id_rdata1;
      bus.ex_rdata2 <= bus.id_rdata2;
      bus.ex_imm <= bus.id_imm;
      bus.ex_pc4 <= bus.id_pc4;
      stall_cnt <= stall_cnt + CNT_W'(stall && !(&stall_cnt));
      flush_cnt <= flush_cnt + CNT_W'(flush && vld && !(&flush_cnt));
    end
  end
  assign bus.ex_valid = ex_vld;
  assign bus.ex_wrReg = ex_wr;
  assign bus.ex_branch = ex_c.branch;
  assign bus.ex_jump = ex_c.jump;
  assign bus.ex_RegWr = ex_c.RegWr;
  assign bus.ex_ALUSrc = ex_c.ALUSrc;
  assign bus.ex_MemWr = ex_c.MemWr;
  assign bus.ex_MemToReg = ex_c.MemToReg;
  assign bus.ex_jumpR = ex_c.jumpR;
  assign bus.ex_ALUcntrl = ex_c.ALUcntrl;
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage of the five-stage MIPS core. Directly downstream of the decode control generator.
- Registers the decoded control bits, register operands and immediate into EX, once per clock.
- Detects load-use hazards: asserts a stall to hold PC and IF/ID, and inserts a bubble into EX.
- Applies flushes from branch/jump resolution.
- Keeps saturating stall and flush event counters for performance debug.

Parameters:
- DATA_W, 32, width of operand data, immediate and PC+4.
- REG_W, 5, register-file address width.
- CNT_W, 16, width of each saturating event counter.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_branch, id_jump, id_RegDst, id_RegWr, id_ALUSrc, id_MemWr, id_MemToReg, id_jumpR  in  1 each  decoder control bits (may carry X)
- id_ALUcntrl  in  2  ALU op: 00 add, 10 sub, 01 xor, 11 slt
- id_rs, id_rt, id_rd  in  REG_W  instruction register fields
- id_rdata1, id_rdata2  in  DATA_W  register-file read data
- id_imm  in  DATA_W  sign-extended immediate
- id_pc4  in  DATA_W  PC+4 of the ID instruction
- flush  in  1  kill the ID instruction (taken branch/jump resolved)
- stall_out  out  1  hold PC and IF/ID this cycle
- ex_valid  out  1  EX holds a real instruction
- ex_branch, ex_jump, ex_RegWr, ex_ALUSrc, ex_MemWr, ex_MemToReg, ex_jumpR  out  1 each  registered controls
- ex_ALUcntrl  out  2  registered ALU op
- ex_rs, ex_rt  out  REG_W  registered source fields (for forwarding)
- ex_wrReg  out  REG_W  destination register
- ex_rdata1, ex_rdata2, ex_imm, ex_pc4  out  DATA_W  registered data
- stall_cnt, flush_cnt  out  CNT_W  saturating event counts

Behaviour:
- Clocking and reset:
  - All state updates on the rising edge of clk.
  - On reset, every ex_* output, the counters and ex_valid are 0. stall_out is 0 while reset is high.
  - Reset mid-operation discards the EX contents.
- Latency: one cycle from ID inputs to ex_* outputs.
- Control sanitising:
  - A control bit is "set" only if it equals 1'b1 by case equality; X or Z counts as 0.
  - Each captured ex_* control bit is the sanitised value AND id_valid.
  - ex_ALUcntrl is captured as-is when id_valid=1, and is 00 otherwise.
- Destination register:
  - ex_wrReg = RegDst set ? id_rd : id_rt.
  - ex_wrReg is forced to 0 when RegWr is not set or for a bubble.
- Source usage:
  - usesRs = id_valid & !jump.
  - usesRt = id_valid & (MemWr | branch | (RegWr & RegDst)), using sanitised bits.
- Load-use hazard (combinational):
  - loadUse = ex_valid & ex_MemToReg & ex_RegWr & (ex_wrReg != 0) & ((usesRs & ex_wrReg == id_rs) | (usesRt & ex_wrReg == id_rt)).
- Outputs and next state:
  - stall_out = loadUse & !flush.
  - Next EX state:
    - If reset: cleared.
    - Else if flush or loadUse: bubble. A bubble has all controls 0, ex_valid=0 and ex_wrReg=0. Data fields load from ID regardless.
    - Else: capture ID.
- Simultaneous flush and loadUse: flush wins. stall_out=0 and flush_cnt increments; stall_cnt does not.
- Counters:
  - stall_cnt increments on each cycle with stall_out=1.
  - flush_cnt increments on each cycle with flush=1 and id_valid=1.
  - Both saturate at all-ones; there is no wrap.
- A stalled instruction is re-presented by upstream and captured on the first non-hazard cycle. Stall lasts exactly one cycle for a single lw.

Decomposition:
- Shared package mips_pkg:
  - ALUcntrl encoding constants ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLT.
  - Packed struct ctrl_t for the control bundle.
  - Constant BUBBLE of type ctrl_t with all fields 0.
- One combinational sub-module, hazard_detect, holding the usesRs/usesRt and loadUse logic.

Test Plan:
- Reset: assert reset 2 cycles with random inputs -> all ex_*=0, counters 0, stall_out 0.
- add, id_rs=1, id_rt=2, id_rd=3, rdata1=5 -> next cycle ex_RegWr=1, ex_wrReg=3, ex_ALUcntrl=00, ex_rdata1=5, ex_valid=1.
- Load-use:
  - Stimulus: lw with rt=5 enters EX; ID holds sub with rs=5.
  - Response: stall_out=1 that cycle; next cycle ex_valid=0 and stall_cnt=1; the following cycle sub is captured with ex_ALUcntrl=10.
- lw with rt=0 in EX, then add with rs=0 -> stall_out=0, no bubble.
- flush=1 together with the load-use condition -> stall_out=0, EX bubble, flush_cnt=1, stall_cnt=0.
- jr with branch=X, RegDst=X -> ex_branch=0, ex_jumpR=1, ex_wrReg=0.
- Saturation: with CNT_W=2, 5 load-use stalls -> stall_cnt=3.
